// File: rtl/fig_04b_block_077_x_select_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fig_04b_block_077_x_select_sequencer
// Brief    : Opcode-driven X-bus select sequencer keeping the from latch in
//            step with the current Sreg (prefix state: Sreg/Dreg, B, ALT).
// Revision : 1.0 - initial release
// ============================================================================
module fig_04b_block_077_x_select_sequencer #(
    parameter logic [3:0] INIT_REG = 4'd0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       op_valid,
    input  logic [7:0] op,
    output logic       op_ready,
    output logic [3:0] xsel,
    output logic [3:0] ysel,
    output logic       fromset,
    output logic       dest_we,
    output logic [3:0] dest_idx,
    output logic [3:0] sreg,
    output logic [3:0] dreg,
    output logic       b_flag,
    output logic [1:0] alt
);

    localparam logic [3:0] c_XSEL_FROM = 4'b0000;
    localparam logic [3:0] c_XSEL_Y    = 4'b0001;
    localparam logic [3:0] c_XSEL_R1   = 4'b0010;
    localparam logic [3:0] c_XSEL_R8   = 4'b0110;
    localparam logic [3:0] c_XSEL_R7   = 4'b1010;
    localparam logic [3:0] c_XSEL_R15  = 4'b1110;
    localparam logic [3:0] c_LINK_REG  = 4'd11;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_WAIT   = 3'd2,
        S_EXEC1  = 3'd3,
        S_EXEC2  = 3'd4,
        S_RELOAD = 3'd5
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_sreg, w_sreg_nxt, r_dreg, w_dreg_nxt;
    logic       r_b, w_b_nxt;
    logic [1:0] r_alt, w_alt_nxt;
    logic       r_prefix, w_prefix_nxt, r_merge, w_merge_nxt;
    logic       r_op_ready, w_ready_nxt;
    logic [3:0] r_xsel, w_xsel_nxt, r_ysel, w_ysel_nxt;
    logic       r_fromset, w_fromset_nxt, r_dest_we, w_we_nxt;
    logic [3:0] r_dest_idx, w_idx_nxt;
    logic       w_ysel_ovr;
    logic       w_last;
    logic       w_skip;
    logic [3:0] w_n;

    assign w_n    = op[3:0];
    assign w_last = ((r_state == S_EXEC1) && !r_prefix && !r_merge) || (r_state == S_EXEC2);
    // The latch already holds INIT_REG unless Sreg moved or the op overwrote that register.
    assign w_skip = (r_sreg == INIT_REG) && !(r_dest_we && (r_dest_idx == INIT_REG));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_INIT;
            r_sreg     <= INIT_REG;
            r_dreg     <= INIT_REG;
            r_b        <= 1'b0;
            r_alt      <= 2'b00;
            r_prefix   <= 1'b0;
            r_merge    <= 1'b0;
            r_op_ready <= 1'b0;
            r_xsel     <= 4'b0000;
            r_ysel     <= 4'd0;
            r_fromset  <= 1'b0;
            r_dest_we  <= 1'b0;
            r_dest_idx <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_sreg     <= w_sreg_nxt;
            r_dreg     <= w_dreg_nxt;
            r_b        <= w_b_nxt;
            r_alt      <= w_alt_nxt;
            r_prefix   <= w_prefix_nxt;
            r_merge    <= w_merge_nxt;
            r_op_ready <= w_ready_nxt;
            r_xsel     <= w_xsel_nxt;
            r_ysel     <= w_ysel_nxt;
            r_fromset  <= w_fromset_nxt;
            r_dest_we  <= w_we_nxt;
            r_dest_idx <= w_idx_nxt;
        end
    end

    // Outputs are computed for the state being entered, so each register shows
    // the values belonging to the state currently held in r_state.
    always_comb begin
        w_state_nxt   = r_state;
        w_sreg_nxt    = r_sreg;
        w_dreg_nxt    = r_dreg;
        w_b_nxt       = r_b;
        w_alt_nxt     = r_alt;
        w_prefix_nxt  = r_prefix;
        w_merge_nxt   = r_merge;
        w_ready_nxt   = 1'b0;
        w_xsel_nxt    = c_XSEL_FROM;
        w_ysel_nxt    = r_sreg;
        w_ysel_ovr    = 1'b0;
        w_fromset_nxt = 1'b0;
        w_we_nxt      = 1'b0;
        w_idx_nxt     = r_dest_idx;
        case (r_state)
            S_INIT: begin
                w_state_nxt   = S_RELOAD;
                w_fromset_nxt = 1'b1;
                w_ysel_nxt    = INIT_REG;
                w_ysel_ovr    = 1'b1;
            end
            S_IDLE: begin
                w_ready_nxt = 1'b1;
                if (op_valid) begin
                    w_ready_nxt  = 1'b0;
                    w_state_nxt  = S_EXEC1;
                    w_prefix_nxt = 1'b0;
                    w_merge_nxt  = 1'b0;
                    if (op inside {8'h3D, 8'h3E, 8'h3F}) begin
                        w_alt_nxt   = op[1:0];
                        w_state_nxt = S_WAIT;
                    end else if (op[7:4] == 4'hB) begin
                        w_sreg_nxt = w_n;
                        w_ysel_nxt = w_n;
                        w_ysel_ovr = 1'b1;
                        if (r_b) begin
                            w_xsel_nxt = c_XSEL_Y;
                            w_we_nxt   = 1'b1;
                            w_idx_nxt  = r_dreg;
                        end else begin
                            w_prefix_nxt  = 1'b1;
                            w_fromset_nxt = 1'b1;
                        end
                    end else if (op[7:4] == 4'h2) begin
                        w_sreg_nxt    = w_n;
                        w_dreg_nxt    = w_n;
                        w_b_nxt       = 1'b1;
                        w_prefix_nxt  = 1'b1;
                        w_ysel_nxt    = w_n;
                        w_ysel_ovr    = 1'b1;
                        w_fromset_nxt = 1'b1;
                    end else if (op[7:4] == 4'h1) begin
                        if (!r_b) begin
                            w_dreg_nxt  = w_n;
                            w_state_nxt = S_WAIT;
                        end else begin
                            w_we_nxt  = 1'b1;
                            w_idx_nxt = w_n;
                        end
                    end else if (op == 8'h70) begin
                        w_merge_nxt = 1'b1;
                        w_xsel_nxt  = c_XSEL_R7;
                    end else if (op == 8'h4C) begin
                        w_xsel_nxt = c_XSEL_R1;
                    end else if ((op[7:4] == 4'h9) && (w_n >= 4'd1) && (w_n <= 4'd4)) begin
                        w_xsel_nxt = c_XSEL_R15;
                        w_we_nxt   = 1'b1;
                        w_idx_nxt  = c_LINK_REG;
                    end else begin
                        w_we_nxt  = 1'b1;
                        w_idx_nxt = r_dreg;
                    end
                end
            end
            S_WAIT, S_RELOAD: begin
                w_state_nxt = S_IDLE;
                w_ready_nxt = 1'b1;
            end
            S_EXEC1: begin
                if (r_merge) begin
                    w_state_nxt = S_EXEC2;
                    w_xsel_nxt  = c_XSEL_R8;
                    w_we_nxt    = 1'b1;
                    w_idx_nxt   = r_dreg;
                end else if (r_prefix) begin
                    w_state_nxt = S_IDLE;
                    w_ready_nxt = 1'b1;
                end
            end
            S_EXEC2: begin
                w_state_nxt = S_EXEC2;
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
        if (w_last) begin
            w_b_nxt    = 1'b0;
            w_alt_nxt  = 2'b00;
            w_sreg_nxt = INIT_REG;
            w_dreg_nxt = INIT_REG;
            if (w_skip) begin
                w_state_nxt = S_IDLE;
                w_ready_nxt = 1'b1;
            end else begin
                w_state_nxt   = S_RELOAD;
                w_fromset_nxt = 1'b1;
            end
        end
        if (!w_ysel_ovr) begin
            w_ysel_nxt = w_sreg_nxt;
        end
    end

    assign op_ready = r_op_ready;
    assign xsel     = r_xsel;
    assign ysel     = r_ysel;
    assign fromset  = r_fromset;
    assign dest_we  = r_dest_we;
    assign dest_idx = r_dest_idx;
    assign sreg     = r_sreg;
    assign dreg     = r_dreg;
    assign b_flag   = r_b;
    assign alt      = r_alt;

endmodule
`default_nettype wire

// File: tb/tb_fig_04b_block_077_x_select_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fig_04b_block_077_x_select_sequencer
// Brief    : Random-opcode bench with a behavioural prefix/exec model feeding a
//            scoreboard that an independent monitor drains.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fig_04b_block_077_x_select_sequencer;

    localparam logic [3:0] INIT_REG = 4'd0;

    logic       clk;
    logic       reset_n;
    logic       op_valid;
    logic [7:0] op;
    logic       op_ready;
    logic [3:0] xsel, ysel, dest_idx, sreg, dreg;
    logic       fromset, dest_we, b_flag;
    logic [1:0] alt;

    fig_04b_block_077_x_select_sequencer #(.INIT_REG(INIT_REG)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .op_valid (op_valid),
        .op       (op),
        .op_ready (op_ready),
        .xsel     (xsel),
        .ysel     (ysel),
        .fromset  (fromset),
        .dest_we  (dest_we),
        .dest_idx (dest_idx),
        .sreg     (sreg),
        .dreg     (dreg),
        .b_flag   (b_flag),
        .alt      (alt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] xsel;
        logic [3:0] ysel;
        logic       fs;
        logic       we;
        logic [3:0] idx;
    } ev_t;

    typedef struct {
        logic [3:0] sreg;
        logic [3:0] dreg;
        logic       b;
        logic [1:0] alt;
        int         low;
    } st_t;

    ev_t evq[$];
    st_t stq[$];

    int errors = 0;
    int checks = 0;

    logic [3:0] m_sreg, m_dreg;
    logic       m_b;
    logic [1:0] m_alt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input logic [3:0] xs, input logic [3:0] ys, input logic fs,
                           input logic we, input logic [3:0] idx);
        ev_t e;
        e.xsel = xs; e.ysel = ys; e.fs = fs; e.we = we; e.idx = idx;
        evq.push_back(e);
    endtask

    task automatic push_st(input int low);
        st_t s;
        s.sreg = m_sreg; s.dreg = m_dreg; s.b = m_b; s.alt = m_alt; s.low = low;
        stq.push_back(s);
    endtask

    task automatic model_reset();
        m_sreg = INIT_REG; m_dreg = INIT_REG; m_b = 1'b0; m_alt = 2'b00;
        push_ev(4'b0000, INIT_REG, 1'b1, 1'b0, 4'd0);
        push_st(-1);
    endtask

    // Behavioural model: per accepted opcode, list the cycles that drive the
    // datapath, then the architectural state seen once op_ready returns.
    task automatic model_op(input logic [7:0] o);
        logic [3:0] n;
        int         nexec;
        logic       last_we;
        logic [3:0] last_idx;
        logic       reload;
        n = o[3:0];
        nexec = 0; last_we = 1'b0; last_idx = 4'd0;
        if (o == 8'h3D || o == 8'h3E || o == 8'h3F) begin
            m_alt = o[1:0];
            push_st(1);
            return;
        end else if (o[7:4] == 4'hB) begin
            m_sreg = n;
            if (!m_b) begin
                push_ev(4'b0000, n, 1'b1, 1'b0, 4'd0);
                push_st(1);
                return;
            end
            push_ev(4'b0001, n, 1'b0, 1'b1, m_dreg);
            nexec = 1; last_we = 1'b1; last_idx = m_dreg;
        end else if (o[7:4] == 4'h2) begin
            m_sreg = n; m_dreg = n; m_b = 1'b1;
            push_ev(4'b0000, n, 1'b1, 1'b0, 4'd0);
            push_st(1);
            return;
        end else if (o[7:4] == 4'h1) begin
            if (!m_b) begin
                m_dreg = n;
                push_st(1);
                return;
            end
            push_ev(4'b0000, m_sreg, 1'b0, 1'b1, n);
            nexec = 1; last_we = 1'b1; last_idx = n;
        end else if (o == 8'h70) begin
            push_ev(4'b1010, m_sreg, 1'b0, 1'b0, 4'd0);
            push_ev(4'b0110, m_sreg, 1'b0, 1'b1, m_dreg);
            nexec = 2; last_we = 1'b1; last_idx = m_dreg;
        end else if (o == 8'h4C) begin
            push_ev(4'b0010, m_sreg, 1'b0, 1'b0, 4'd0);
            nexec = 1;
        end else if (o[7:4] == 4'h9 && n >= 4'd1 && n <= 4'd4) begin
            push_ev(4'b1110, m_sreg, 1'b0, 1'b1, 4'd11);
            nexec = 1; last_we = 1'b1; last_idx = 4'd11;
        end else begin
            push_ev(4'b0000, m_sreg, 1'b0, 1'b1, m_dreg);
            nexec = 1; last_we = 1'b1; last_idx = m_dreg;
        end
        reload = !((m_sreg == INIT_REG) && !(last_we && last_idx == INIT_REG));
        if (reload) push_ev(4'b0000, INIT_REG, 1'b1, 1'b0, 4'd0);
        m_sreg = INIT_REG; m_dreg = INIT_REG; m_b = 1'b0; m_alt = 2'b00;
        push_st(nexec + (reload ? 1 : 0));
    endtask

    // Monitor
    logic prev_ready = 1'b0;
    int   lowcnt = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_ready = 1'b0;
            lowcnt = 0;
        end else begin
            if (fromset || dest_we || xsel != 4'b0000) begin
                if (evq.size() == 0) begin
                    check("unexpected_event", {xsel, ysel, 3'b0, fromset, 3'b0, dest_we}, 32'd0);
                end else begin
                    ev_t e;
                    e = evq.pop_front();
                    check("ev_xsel", xsel, e.xsel);
                    check("ev_ysel", ysel, e.ysel);
                    check("ev_fromset", fromset, e.fs);
                    check("ev_dest_we", dest_we, e.we);
                    if (e.we) check("ev_dest_idx", dest_idx, e.idx);
                end
            end
            if (op_ready && !prev_ready) begin
                if (stq.size() == 0) begin
                    check("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    st_t s;
                    s = stq.pop_front();
                    check("st_sreg", sreg, s.sreg);
                    check("st_dreg", dreg, s.dreg);
                    check("st_b_flag", b_flag, s.b);
                    check("st_alt", alt, s.alt);
                    check("st_idle_ysel", ysel, s.sreg);
                    if (s.low >= 0) check("st_busy_cycles", lowcnt, s.low);
                end
            end
            if (op_ready) lowcnt = 0;
            else lowcnt = lowcnt + 1;
            prev_ready = op_ready;
        end
    end

    task automatic send(input logic [7:0] o);
        int k;
        k = 0;
        @(negedge clk);
        while (!op_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!op_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        model_op(o);
        op = o;
        op_valid = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        op = 8'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_op_ready"}, op_ready, 1'b0);
        check({tag, "_xsel"}, xsel, 4'b0000);
        check({tag, "_fromset"}, fromset, 1'b0);
        check({tag, "_dest_we"}, dest_we, 1'b0);
        check({tag, "_dest_idx"}, dest_idx, 4'd0);
        check({tag, "_ysel"}, ysel, 4'd0);
        check({tag, "_sreg"}, sreg, INIT_REG);
        check({tag, "_dreg"}, dreg, INIT_REG);
        check({tag, "_b_flag"}, b_flag, 1'b0);
        check({tag, "_alt"}, alt, 2'b00);
    endtask

    function automatic logic [7:0] rand_op();
        logic [7:0] o;
        case ($urandom_range(0, 8))
            0: o = 8'h3D + 8'($urandom_range(0, 2));
            1: o = 8'hB0 | 8'($urandom_range(0, 15));
            2: o = 8'h20 | 8'($urandom_range(0, 15));
            3: o = 8'h10 | 8'($urandom_range(0, 15));
            4: o = 8'h70;
            5: o = 8'h4C;
            6: o = 8'h90 | 8'($urandom_range(1, 4));
            default: o = 8'($urandom);
        endcase
        return o;
    endfunction

    initial begin
        int k;
        logic found;
        reset_n = 1'b0;
        op_valid = 1'b0;
        op = 8'h00;
        #2 check_reset_outputs("reset");
        model_reset();
        @(negedge clk);
        #1 reset_n = 1'b1;

        send(8'hB5); send(8'h50);
        send(8'h23); send(8'h16);
        send(8'h14); send(8'h70);
        send(8'h3D); send(8'h94);

        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(rand_op());
        end

        // Reset in the middle of MERGE EXEC2
        send(8'h4C);
        send(8'h14);
        send(8'h70);
        found = 1'b0;
        k = 0;
        while (!found && k < 10) begin
            @(negedge clk);
            if (xsel == 4'b0110) found = 1'b1;
            k++;
        end
        check("merge_exec2_seen", found, 1'b1);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("midreset");
        evq.delete();
        stq.delete();
        model_reset();
        @(negedge clk);
        #1 reset_n = 1'b1;

        for (int i = 0; i < 40; i++) send(rand_op());

        k = 0;
        while ((evq.size() != 0 || stq.size() != 0 || !op_ready) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("evq_drained", evq.size(), 32'd0);
        check("stq_drained", stq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
